// File: rtl/ddc_nco_tdm.sv
// TDM NCO phase generator: one channel's acc+poff per cycle, round-robin, 1-cycle output latency.
// Config is valid/ready, one request in flight; ready drops until the update lands at its channel's slot.
module ddc_nco_tdm #(
    parameter int N_CH    = 4,
    parameter int CH_W    = 2,
    parameter int PHASE_W = 20
) (
    input  logic               dev_clk,
    input  logic               dev_rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [PHASE_W-1:0] cfg_pinc,
    input  logic [PHASE_W-1:0] cfg_poff,
    input  logic               sync_in,
    output logic               busy,
    output logic               phase_valid,
    output logic [CH_W-1:0]    phase_ch,
    output logic [PHASE_W-1:0] phase_out
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t             state;
    logic [CH_W-1:0]    ch_cnt;
    logic [CH_W-1:0]    lat_ch;
    logic [PHASE_W-1:0] lat_pinc;
    logic [PHASE_W-1:0] lat_poff;

    logic [PHASE_W-1:0] acc      [N_CH];
    logic [PHASE_W-1:0] pinc_tbl [N_CH];
    logic [PHASE_W-1:0] poff_tbl [N_CH];

    logic cfg_hs;
    logic apply;

    assign cfg_hs = cfg_valid && cfg_ready;
    assign apply  = (state == WAIT) && (ch_cnt == lat_ch);

    // N_CH == 2**CH_W, so the slot counter wraps by natural overflow.
    always_ff @(posedge dev_clk) begin
        if (dev_rst) begin
            ch_cnt <= '0;
        end else if (sync_in) begin
            ch_cnt <= '0;
        end else begin
            ch_cnt <= ch_cnt + CH_W'(1);
        end
    end

    // Output reads the tables before this cycle's writes land.
    always_ff @(posedge dev_clk) begin
        if (dev_rst) begin
            phase_valid <= 1'b0;
            phase_ch    <= '0;
            phase_out   <= '0;
        end else begin
            phase_valid <= 1'b1;
            phase_ch    <= ch_cnt;
            phase_out   <= acc[ch_cnt] + poff_tbl[ch_cnt];
        end
    end

    always_ff @(posedge dev_clk) begin
        if (dev_rst) begin
            for (int i = 0; i < N_CH; i++) begin
                pinc_tbl[i] <= '0;
                poff_tbl[i] <= '0;
            end
        end else if (apply) begin
            pinc_tbl[lat_ch] <= lat_pinc;
            poff_tbl[lat_ch] <= lat_poff;
        end
    end

    // A fresh config restarts its channel at zero phase; sync clears every channel.
    always_ff @(posedge dev_clk) begin
        if (dev_rst || sync_in) begin
            for (int i = 0; i < N_CH; i++) begin
                acc[i] <= '0;
            end
        end else if (apply) begin
            acc[ch_cnt] <= '0;
        end else begin
            acc[ch_cnt] <= acc[ch_cnt] + pinc_tbl[ch_cnt];
        end
    end

    always_ff @(posedge dev_clk) begin
        if (dev_rst) begin
            state     <= IDLE;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            lat_ch    <= '0;
            lat_pinc  <= '0;
            lat_poff  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_hs) begin
                        state     <= WAIT;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                        lat_ch    <= cfg_ch;
                        lat_pinc  <= cfg_pinc;
                        lat_poff  <= cfg_poff;
                    end else begin
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                WAIT: begin
                    if (apply) begin
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddc_nco_tdm.sv
// Directed and randomized bench for ddc_nco_tdm against a per-slot behavioural model.
module tb_ddc_nco_tdm;

    localparam int MASK = 'hFFFFF;

    logic        dev_clk = 1'b0;
    logic        dev_rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [19:0] cfg_pinc;
    logic [19:0] cfg_poff;
    logic        sync_in;
    logic        busy;
    logic        phase_valid;
    logic [1:0]  phase_ch;
    logic [19:0] phase_out;

    always #5 dev_clk = ~dev_clk;

    ddc_nco_tdm dut (
        .dev_clk     (dev_clk),
        .dev_rst     (dev_rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_pinc    (cfg_pinc),
        .cfg_poff    (cfg_poff),
        .sync_in     (sync_in),
        .busy        (busy),
        .phase_valid (phase_valid),
        .phase_ch    (phase_ch),
        .phase_out   (phase_out)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: channel tables, slot counter and one pending request.
    int m_acc [4];
    int m_pinc[4];
    int m_poff[4];
    int m_cnt;
    bit m_pend;
    int m_pch, m_ppinc, m_ppoff;
    bit m_ready, m_busy, m_valid, m_hs;
    int m_ch, m_out;

    int got0[$];
    int got1[$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int nxt[4];
        m_hs = 1'b0;
        if (dev_rst) begin
            for (int i = 0; i < 4; i++) begin
                m_acc[i] = 0; m_pinc[i] = 0; m_poff[i] = 0;
            end
            m_cnt = 0; m_pend = 0; m_ready = 0; m_busy = 0;
            m_valid = 0; m_ch = 0; m_out = 0;
        end else begin
            m_out   = (m_acc[m_cnt] + m_poff[m_cnt]) & MASK;
            m_ch    = m_cnt;
            m_valid = 1;
            nxt = m_acc;
            nxt[m_cnt] = (m_acc[m_cnt] + m_pinc[m_cnt]) & MASK;
            if (m_pend && m_pch == m_cnt) begin
                m_pinc[m_pch] = m_ppinc;
                m_poff[m_pch] = m_ppoff;
                nxt[m_pch] = 0;
                m_pend = 0; m_busy = 0; m_ready = 1;
            end else if (cfg_valid && m_ready) begin
                m_hs = 1;
                m_pch = int'(cfg_ch); m_ppinc = int'(cfg_pinc); m_ppoff = int'(cfg_poff);
                m_pend = 1; m_busy = 1; m_ready = 0;
            end else if (!m_pend) begin
                m_ready = 1;
            end
            if (sync_in) begin
                for (int i = 0; i < 4; i++) nxt[i] = 0;
                m_cnt = 0;
            end else begin
                m_cnt = (m_cnt + 1) % 4;
            end
            m_acc = nxt;
        end
        @(posedge dev_clk);
        #1;
        check("phase_valid", phase_valid, m_valid);
        check("phase_ch", phase_ch, m_ch);
        check("phase_out", phase_out, m_out);
        check("cfg_ready", cfg_ready, m_ready);
        check("busy", busy, m_busy);
    endtask

    task automatic send(int ch, int pi, int po, output int waited);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_pinc  = 20'(pi);
        cfg_poff  = 20'(po);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!m_hs && waited < 40);
        check("send_accept", m_hs, 1);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("busy_clear", busy, 0);
    endtask

    // Collect phase_out values seen for channels a and b over n cycles.
    task automatic collect(int a, int b, int n);
        got0.delete();
        got1.delete();
        for (int i = 0; i < n; i++) begin
            tick();
            if (int'(phase_ch) == a) got0.push_back(int'(phase_out));
            if (int'(phase_ch) == b) got1.push_back(int'(phase_out));
        end
    endtask

    initial begin
        int w, w2, n;
        dev_rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0;
        cfg_pinc = '0; cfg_poff = '0; sync_in = 1'b0;

        // Reset and idle free-run
        repeat (3) tick();
        check("rst_valid", phase_valid, 0);
        check("rst_ready", cfg_ready, 0);
        dev_rst = 1'b0;
        tick();
        check("first_valid", phase_valid, 1);
        check("first_ch", phase_ch, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("idle_ch", phase_ch, i % 4);
            check("idle_out", phase_out, 0);
            check("idle_ready", cfg_ready, 1);
        end

        // Single config on channel 1
        send(1, 'h00100, 'h00010, w);
        check("single_busy", busy, 1);
        wait_idle();
        collect(1, 0, 12);
        check("single_v0", got0[0], 'h00010);
        check("single_v1", got0[1], 'h00110);
        check("single_v2", got0[2], 'h00210);
        check("single_ch0", got1[2], 0);

        // Accumulator wrap
        send(2, 'hFFFFF, 'h00001, w);
        wait_idle();
        collect(2, 3, 16);
        check("wrap_v0", got0[0], 'h00001);
        check("wrap_v1", got0[1], 'h00000);
        check("wrap_v2", got0[2], 'hFFFFF);
        check("wrap_v3", got0[3], 'hFFFFE);
        send(2, 'h80000, 'h00000, w);
        wait_idle();
        collect(2, 3, 12);
        check("half_v0", got0[0], 'h00000);
        check("half_v1", got0[1], 'h80000);
        check("half_v2", got0[2], 'h00000);

        // Back-to-back requests under backpressure
        send(3, 'h10, 0, w);
        check("bp_ready_low", cfg_ready, 0);
        send(0, 'h20, 0, w2);
        check("bp_second_waited", (w2 > 1), 1);
        wait_idle();
        collect(0, 3, 12);
        check("bp_ch0_v0", got0[0], 0);
        check("bp_ch0_v1", got0[1], 'h20);
        check("bp_ch3_step", (got1[1] - got1[0]) & MASK, 'h10);

        // Resync mid-frame
        dev_rst = 1'b1;
        repeat (2) tick();
        dev_rst = 1'b0;
        send(0, 'h40, 'h5, w);
        wait_idle();
        send(1, 'h40, 'h7, w);
        wait_idle();
        n = 0;
        while (phase_ch != 2'd1 && n < 8) begin tick(); n++; end
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        tick();
        check("sync_ch", phase_ch, 0);
        check("sync_out", phase_out, 'h5);
        tick();
        check("sync_ch1", phase_ch, 1);
        check("sync_out1", phase_out, 'h7);
        repeat (3) tick();
        check("sync_ch0_next", phase_ch, 0);
        check("sync_out0_next", phase_out, 'h45);

        // Reset while a config is pending
        send(3, 'h123, 'h55, w);
        check("mid_busy", busy, 1);
        dev_rst = 1'b1;
        repeat (2) tick();
        dev_rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("mid_out_zero", phase_out, 0);
        end

        // Randomized traffic with held requests, resyncs and rare resets
        for (int i = 0; i < 2000; i++) begin
            if (cfg_valid && m_hs) cfg_valid = 1'b0;
            if (!cfg_valid && $urandom_range(0, 5) == 0) begin
                cfg_valid = 1'b1;
                cfg_ch    = 2'($urandom_range(0, 3));
                cfg_pinc  = 20'($urandom & MASK);
                cfg_poff  = 20'($urandom & MASK);
            end
            sync_in = ($urandom_range(0, 39) == 0);
            dev_rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        dev_rst = 1'b0; sync_in = 1'b0; cfg_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
